// File: rtl/ntt_butterfly_scheduler_if.sv
// Scheduler <-> RAM/ROM/compute-unit control bundle.
// master = scheduler side; slave = the datapath (or a bench) that consumes the strobes.
interface ntt_butterfly_scheduler_if #(parameter int LOGN = 9);
    logic            start;
    logic [1:0]      mode;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [LOGN-1:0] rd_addr_a;
    logic [LOGN-1:0] rd_addr_b;
    logic [LOGN-1:0] tw_addr;
    logic            cu_forward;
    logic            cu_reg_forward;
    logic            cu_forward_delayed;
    logic            cu_point_mul;
    logic            wr_en;
    logic            wr_en_a;
    logic [LOGN-1:0] wr_addr_a;
    logic [LOGN-1:0] wr_addr_b;

    modport master (
        input  start, mode,
        output busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               cu_forward, cu_reg_forward, cu_forward_delayed, cu_point_mul,
               wr_en, wr_en_a, wr_addr_a, wr_addr_b
    );

    modport slave (
        output start, mode,
        input  busy, done, rd_en, rd_addr_a, rd_addr_b, tw_addr,
               cu_forward, cu_reg_forward, cu_forward_delayed, cu_point_mul,
               wr_en, wr_en_a, wr_addr_a, wr_addr_b
    );
endinterface

// File: rtl/ntt_butterfly_scheduler.sv
// Issues one butterfly (or pointwise) read per cycle for CT/GS NTT or pointwise mult and
// lines write-back up with the compute unit; layers are separated by a full drain (no RAW).
module ntt_butterfly_scheduler #(
    parameter int LOGN      = 9,
    parameter int FWD_DELAY = 11,
    parameter int LAT_FWD   = 13,
    parameter int LAT_INV   = 12,
    parameter int LAT_PMUL  = 12
) (
    input  logic clk,
    input  logic reset,
    ntt_butterfly_scheduler_if.master bus
);
    localparam int N       = 1 << LOGN;
    localparam int LAT_MAX = (LAT_FWD > LAT_INV) ? ((LAT_FWD > LAT_PMUL) ? LAT_FWD : LAT_PMUL)
                                                 : ((LAT_INV > LAT_PMUL) ? LAT_INV : LAT_PMUL);
    localparam int LW      = $clog2(LOGN + 1);
    localparam int DW      = $clog2(LAT_MAX + 1);

    localparam logic [1:0] M_FWD  = 2'd0;
    localparam logic [1:0] M_INV  = 2'd1;
    localparam logic [1:0] M_PMUL = 2'd2;
    localparam logic [1:0] M_NOP  = 2'd3;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [1:0]      mode_q;
    logic [LOGN-1:0] j_q, j_max;
    logic [LW-1:0]   l_q, sh;
    logic [DW-1:0]   d_q, lat;
    logic            issue, j_last, d_last, pmul, l_last;
    logic [LOGN-1:0] g, k, ca, cb, ctw;
    logic [LAT_MAX:0]      vld_p;
    logic [LOGN-1:0]       a_p [0:LAT_MAX];
    logic [LOGN-1:0]       b_p [0:LAT_MAX];
    logic [FWD_DELAY-1:0]  fwd_sr;

    assign pmul   = (mode_q == M_PMUL);
    assign l_last = (l_q == LW'(LOGN - 1));
    assign j_last = (j_q == j_max);
    assign d_last = (d_q == lat);

    always_comb begin
        case (mode_q)
            M_FWD:   lat = DW'(LAT_FWD);
            M_INV:   lat = DW'(LAT_INV);
            default: lat = DW'(LAT_PMUL);
        endcase
        j_max = pmul ? LOGN'(N - 1) : LOGN'(N / 2 - 1);
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        case (state_q)
            S_IDLE:  if (bus.start) state_d = (bus.mode == M_NOP) ? S_DONE : S_ISSUE;
            S_ISSUE: begin
                issue = 1'b1;
                if (j_last) state_d = S_DRAIN;
            end
            S_DRAIN: if (d_last) state_d = (pmul || l_last) ? S_DONE : S_ISSUE;
            default: state_d = S_IDLE;
        endcase
    end

    // sh = log2(half): CT shrinks the span per layer, GS grows it.
    always_comb begin
        sh  = (mode_q == M_INV) ? l_q : LW'(LOGN - 1) - l_q;
        g   = j_q >> sh;
        k   = j_q & ((LOGN'(1) << sh) - LOGN'(1));
        ca  = ((g << sh) << 1) | k;
        cb  = ca | (LOGN'(1) << sh);
        ctw = (LOGN'(1) << (LW'(LOGN - 1) - sh)) + g;
        if (pmul) begin
            ca  = j_q;
            cb  = j_q;
            ctw = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q <= '0;
            j_q    <= '0;
            l_q    <= '0;
            d_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (bus.start) begin
                    mode_q <= bus.mode;
                    j_q    <= '0;
                    l_q    <= '0;
                    d_q    <= '0;
                end
                S_ISSUE: begin
                    j_q <= j_last ? '0 : j_q + LOGN'(1);
                    d_q <= '0;
                end
                S_DRAIN: begin
                    d_q <= d_q + DW'(1);
                    if (d_last && !pmul) l_q <= l_last ? '0 : l_q + LW'(1);
                end
                default: ;
            endcase
        end
    end

    // Stage 0 of the pipe is the read strobe itself; stage LAT feeds the write-back register.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p <= '0;
            for (int i = 0; i <= LAT_MAX; i++) begin
                a_p[i] <= '0;
                b_p[i] <= '0;
            end
            fwd_sr                 <= '0;
            bus.tw_addr            <= '0;
            bus.cu_forward         <= 1'b0;
            bus.cu_point_mul       <= 1'b0;
            bus.wr_en              <= 1'b0;
            bus.wr_en_a            <= 1'b0;
            bus.wr_addr_a          <= '0;
            bus.wr_addr_b          <= '0;
            bus.busy               <= 1'b0;
            bus.done               <= 1'b0;
        end else begin
            vld_p  <= {vld_p[LAT_MAX-1:0], issue};
            a_p[0] <= issue ? ca : '0;
            b_p[0] <= issue ? cb : '0;
            for (int i = 1; i <= LAT_MAX; i++) begin
                a_p[i] <= a_p[i-1];
                b_p[i] <= b_p[i-1];
            end
            bus.tw_addr      <= issue ? ctw : '0;
            bus.cu_forward   <= vld_p[0] && (mode_q == M_FWD);
            bus.cu_point_mul <= vld_p[0] && pmul;
            fwd_sr           <= {fwd_sr[FWD_DELAY-2:0], bus.cu_forward};
            bus.wr_en        <= vld_p[lat];
            bus.wr_en_a      <= vld_p[lat] && !pmul;
            bus.wr_addr_a    <= a_p[lat];
            bus.wr_addr_b    <= b_p[lat];
            bus.busy         <= (state_q == S_ISSUE) || (state_q == S_DRAIN);
            bus.done         <= (state_q == S_DONE);
        end
    end

    assign bus.rd_en              = vld_p[0];
    assign bus.rd_addr_a          = a_p[0];
    assign bus.rd_addr_b          = b_p[0];
    assign bus.cu_reg_forward     = fwd_sr[0];
    assign bus.cu_forward_delayed = fwd_sr[FWD_DELAY-1];
endmodule

// File: tb/tb_ntt_butterfly_scheduler.sv
// Directed bench for ntt_butterfly_scheduler at LOGN=3: address order, cycle timing,
// ignored start, mid-run reset and back-to-back operations.
module tb_ntt_butterfly_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    ntt_butterfly_scheduler_if #(.LOGN(3)) bus ();

    ntt_butterfly_scheduler #(.LOGN(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Hand-derived butterfly order for N=8.
    int fa [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
    int fb [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
    int ft [12] = '{1,1,1,1, 2,2,3,3, 4,5,6,7};
    int ia [12] = '{0,2,4,6, 0,1,4,5, 0,1,2,3};
    int ib [12] = '{1,3,5,7, 2,3,6,7, 4,5,6,7};
    int it [12] = '{4,5,6,7, 2,2,3,3, 1,1,1,1};

    int ea [12];
    int eb [12];
    int et [12];

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int exp_rd(input int c, input int nl, input int per, input int iss);
        int t;
        t = c - 1;
        if (t < 0 || t >= nl * per) return 0;
        return ((t % per) < iss) ? 1 : 0;
    endfunction

    // Start sampled at edge 0; observe every cycle through the expected done cycle.
    task automatic run_op(input logic [1:0] m, input int exp_done, input bit poke);
        int lat, iss, nl, per, n, ri, wi, erc;
        lat = (m == 2'd0) ? 13 : 12;
        iss = (m == 2'd2) ? 8 : 4;
        nl  = (m == 2'd3) ? 0 : (m == 2'd2) ? 1 : 3;
        per = iss + 1 + lat;
        n   = nl * iss;
        ri  = 0;
        wi  = 0;
        for (int i = 0; i < 12; i++) begin
            ea[i] = (m == 2'd1) ? ia[i] : fa[i];
            eb[i] = (m == 2'd1) ? ib[i] : fb[i];
            et[i] = (m == 2'd1) ? it[i] : ft[i];
        end
        bus.mode  = m;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c <= exp_done; c++) begin
            @(posedge clk);
            #1;
            chk("done",     bus.done,  (c == exp_done) ? 1 : 0);
            chk("busy",     bus.busy,  (m != 2'd3 && c < exp_done) ? 1 : 0);
            chk("rd_en",    bus.rd_en, exp_rd(c, nl, per, iss));
            chk("wr_en",    bus.wr_en, exp_rd(c - 1 - lat, nl, per, iss));
            chk("cu_fwd",   bus.cu_forward,         (m == 2'd0) ? exp_rd(c - 1,  nl, per, iss) : 0);
            chk("cu_regf",  bus.cu_reg_forward,     (m == 2'd0) ? exp_rd(c - 2,  nl, per, iss) : 0);
            chk("cu_fdly",  bus.cu_forward_delayed, (m == 2'd0) ? exp_rd(c - 12, nl, per, iss) : 0);
            chk("cu_pmul",  bus.cu_point_mul,       (m == 2'd2) ? exp_rd(c - 1,  nl, per, iss) : 0);
            if (bus.rd_en) begin
                if (ri < n) begin
                    erc = (ri / iss) * per + (ri % iss) + 1;
                    chk("rd_cycle", c, erc);
                    chk("rd_addr_a", int'(bus.rd_addr_a), (m == 2'd2) ? ri : ea[ri]);
                    chk("rd_addr_b", int'(bus.rd_addr_b), (m == 2'd2) ? ri : eb[ri]);
                    chk("tw_addr",   int'(bus.tw_addr),   (m == 2'd2) ? 0  : et[ri]);
                end
                ri++;
            end
            if (bus.wr_en) begin
                if (wi < n) begin
                    erc = (wi / iss) * per + (wi % iss) + 2 + lat;
                    chk("wr_cycle", c, erc);
                    chk("wr_en_a", bus.wr_en_a, (m == 2'd2) ? 0 : 1);
                    chk("wr_addr_b", int'(bus.wr_addr_b), (m == 2'd2) ? wi : eb[wi]);
                    if (m != 2'd2) chk("wr_addr_a", int'(bus.wr_addr_a), ea[wi]);
                end
                wi++;
            end
            if (poke && c == 5) begin
                bus.start = 1'b1;
                bus.mode  = (m == 2'd0) ? 2'd1 : 2'd0;
            end
            if (poke && c == 6) bus.start = 1'b0;
        end
        chk("rd_total", ri, n);
        chk("wr_total", wi, n);
    endtask

    initial begin
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.mode  = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", int'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.wr_en_a,
                              bus.cu_forward, bus.cu_reg_forward, bus.cu_forward_delayed,
                              bus.cu_point_mul, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                              bus.wr_addr_a, bus.wr_addr_b}), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Forward with a stray start mid-run, then inverse/pointwise/reserved back-to-back.
        run_op(2'd0, 55, 1'b1);
        run_op(2'd1, 52, 1'b0);
        run_op(2'd2, 22, 1'b0);
        run_op(2'd3, 1,  1'b0);

        // Abort a forward run with reset sampled at cycle 20.
        bus.mode  = 2'd0;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int c = 1; c < 20; c++) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", bus.busy, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_outs", int'({bus.busy, bus.done, bus.rd_en, bus.wr_en, bus.wr_en_a,
                                bus.cu_forward, bus.cu_reg_forward, bus.cu_forward_delayed,
                                bus.cu_point_mul, bus.rd_addr_a, bus.rd_addr_b, bus.tw_addr,
                                bus.wr_addr_a, bus.wr_addr_b}), 0);
        reset = 1'b0;
        for (int c = 0; c < 30; c++) begin
            @(posedge clk);
            #1;
            chk("post_rst_wr", bus.wr_en, 0);
            chk("post_rst_rd", bus.rd_en, 0);
        end
        run_op(2'd2, 22, 1'b0);
        run_op(2'd0, 55, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
